// File: rtl/hit_judge.sv
// Two-player hit arbitration evaluated once per synchronized frame tick.
// Optional macro HIT_COOLDOWN_EN adds a per-attacker 12-tick cooldown after a landed hit.
module hit_judge (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       st,
   input  logic [9:0] BallX1,
   input  logic [9:0] BallY1,
   input  logic [9:0] BallX2,
   input  logic [9:0] BallY2,
   input  logic       fight_1,
   input  logic       kick_1,
   input  logic       dodge_1,
   input  logic       jump_1,
   input  logic       fight_2,
   input  logic       kick_2,
   input  logic       dodge_2,
   input  logic       jump_2,
   output logic [1:0] back1,
   output logic [1:0] back2,
   output logic [6:0] hp1,
   output logic [6:0] hp2,
   output logic       p1win,
   output logic       p2win
);

   localparam logic [6:0] HP_INIT      = 7'd100;
   localparam logic [9:0] FIGHT_RANGE  = 10'd60;
   localparam logic [9:0] KICK_RANGE   = 10'd70;
   localparam logic [9:0] Y_RANGE      = 10'd50;
   localparam logic [6:0] FIGHT_DMG    = 7'd5;
   localparam logic [6:0] KICK_DMG     = 7'd8;
   localparam logic [3:0] STUN_FRAMES  = 4'd8;
   localparam logic [3:0] DODGE_FRAMES = 4'd4;
   localparam logic [1:0] BK_NONE      = 2'd0;
   localparam logic [1:0] BK_DODGE     = 2'd1;
   localparam logic [1:0] BK_KNOCK     = 2'd2;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_FIGHT = 2'd1, S_OVER = 2'd2} state_t;

   state_t     r_state;
   logic [1:0] r_sync;
   logic       r_sync_q;
   logic [6:0] r_hp1, r_hp2;
   logic [1:0] r_back1, r_back2;
   logic [3:0] r_tmr1, r_tmr2;
   logic       r_p1win, r_p2win;

   logic       w_tick;
   logic [9:0] w_dx, w_dy;
   logic       w_in_fight, w_in_kick, w_in_y;
   logic [3:0] w_tmr1_dec, w_tmr2_dec;
   logic       w_stun1, w_stun2;
   logic       w_cd1_ok, w_cd2_ok;
   logic       w_a1_kick, w_a1_punch, w_a1, w_a2_kick, w_a2_punch, w_a2;
   logic       w_dodge1, w_dmg1, w_dodge2, w_dmg2;
   logic [6:0] w_hp1_next, w_hp2_next;
   logic       w_over_next;
   logic [1:0] w_back1_next, w_back2_next;
   logic [3:0] w_tmr1_next, w_tmr2_next;

   function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   function automatic logic [6:0] sat_sub(input logic [6:0] hp, input logic [6:0] dmg);
      return (hp >= dmg) ? (hp - dmg) : 7'd0;
   endfunction

   function automatic logic [3:0] dec4(input logic [3:0] v);
      return (v != 4'd0) ? (v - 4'd1) : 4'd0;
   endfunction

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_sync   <= 2'b00;
         r_sync_q <= 1'b0;
      end else begin
         r_sync   <= {r_sync[0], frame_clk};
         r_sync_q <= r_sync[1];
      end
   end

   assign w_tick     = r_sync[1] & ~r_sync_q;
   assign w_dx       = abs_diff(BallX1, BallX2);
   assign w_dy       = abs_diff(BallY1, BallY2);
   assign w_in_fight = (w_dx <= FIGHT_RANGE);
   assign w_in_kick  = (w_dx <= KICK_RANGE);
   assign w_in_y     = (w_dy <= Y_RANGE);

   // A victim stays protected only if its knockback survives this tick's decrement,
   // so a held attack re-lands exactly STUN_FRAMES ticks after the previous hit.
   assign w_tmr1_dec = dec4(r_tmr1);
   assign w_tmr2_dec = dec4(r_tmr2);
   assign w_stun1    = (r_back1 == BK_KNOCK) && (w_tmr1_dec != 4'd0);
   assign w_stun2    = (r_back2 == BK_KNOCK) && (w_tmr2_dec != 4'd0);

   assign w_a1_kick  = kick_1 & w_in_kick;
   assign w_a1_punch = fight_1 & w_in_fight;
   assign w_a1       = (w_a1_kick | w_a1_punch) & w_in_y & ~w_stun2 & w_cd1_ok;
   assign w_a2_kick  = kick_2 & w_in_kick;
   assign w_a2_punch = fight_2 & w_in_fight;
   assign w_a2       = (w_a2_kick | w_a2_punch) & w_in_y & ~w_stun1 & w_cd2_ok;

   // Dodge beats everything; a jump only evades punches.
   assign w_dodge2   = w_a1 & dodge_2;
   assign w_dmg2     = w_a1 & ~dodge_2 & (w_a1_kick | ~jump_2);
   assign w_dodge1   = w_a2 & dodge_1;
   assign w_dmg1     = w_a2 & ~dodge_1 & (w_a2_kick | ~jump_1);

   assign w_hp2_next  = w_dmg2 ? sat_sub(r_hp2, w_a1_kick ? KICK_DMG : FIGHT_DMG) : r_hp2;
   assign w_hp1_next  = w_dmg1 ? sat_sub(r_hp1, w_a2_kick ? KICK_DMG : FIGHT_DMG) : r_hp1;
   assign w_over_next = (w_hp1_next == 7'd0) || (w_hp2_next == 7'd0);

   // Next reaction code and timer for each player while fighting.
   always_comb begin
      w_back1_next = r_back1;
      w_tmr1_next  = w_tmr1_dec;
      if (w_dmg1) begin
         w_back1_next = BK_KNOCK;
         w_tmr1_next  = STUN_FRAMES;
      end else if (w_dodge1) begin
         w_back1_next = BK_DODGE;
         w_tmr1_next  = DODGE_FRAMES;
      end else if (w_tmr1_dec == 4'd0) begin
         w_back1_next = BK_NONE;
      end else begin
         w_back1_next = r_back1;
      end
      w_back2_next = r_back2;
      w_tmr2_next  = w_tmr2_dec;
      if (w_dmg2) begin
         w_back2_next = BK_KNOCK;
         w_tmr2_next  = STUN_FRAMES;
      end else if (w_dodge2) begin
         w_back2_next = BK_DODGE;
         w_tmr2_next  = DODGE_FRAMES;
      end else if (w_tmr2_dec == 4'd0) begin
         w_back2_next = BK_NONE;
      end else begin
         w_back2_next = r_back2;
      end
   end

`ifdef HIT_COOLDOWN_EN
   localparam logic [3:0] CD_LOAD = 4'd12;
   logic [3:0] r_cd1, r_cd2;
   logic       w_land1, w_land2;

   assign w_land1  = w_dodge2 | w_dmg2;
   assign w_land2  = w_dodge1 | w_dmg1;
   assign w_cd1_ok = (dec4(r_cd1) == 4'd0);
   assign w_cd2_ok = (dec4(r_cd2) == 4'd0);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_cd1 <= 4'd0;
         r_cd2 <= 4'd0;
      end else if (w_tick) begin
         if (st && (r_state == S_FIGHT) && !w_over_next) begin
            r_cd1 <= w_land1 ? CD_LOAD : dec4(r_cd1);
            r_cd2 <= w_land2 ? CD_LOAD : dec4(r_cd2);
         end else begin
            r_cd1 <= 4'd0;
            r_cd2 <= 4'd0;
         end
      end
   end
`else
   assign w_cd1_ok = 1'b1;
   assign w_cd2_ok = 1'b1;
`endif

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_hp1   <= HP_INIT;
         r_hp2   <= HP_INIT;
         r_back1 <= BK_NONE;
         r_back2 <= BK_NONE;
         r_tmr1  <= 4'd0;
         r_tmr2  <= 4'd0;
         r_p1win <= 1'b0;
         r_p2win <= 1'b0;
      end else if (w_tick) begin
         if (!st) begin
            r_state <= S_IDLE;
            r_back1 <= BK_NONE;
            r_back2 <= BK_NONE;
            r_tmr1  <= 4'd0;
            r_tmr2  <= 4'd0;
            r_p1win <= 1'b0;
            r_p2win <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state <= S_FIGHT;
                  r_hp1   <= HP_INIT;
                  r_hp2   <= HP_INIT;
                  r_back1 <= BK_NONE;
                  r_back2 <= BK_NONE;
                  r_tmr1  <= 4'd0;
                  r_tmr2  <= 4'd0;
                  r_p1win <= 1'b0;
                  r_p2win <= 1'b0;
               end
               S_FIGHT: begin
                  r_hp1 <= w_hp1_next;
                  r_hp2 <= w_hp2_next;
                  if (w_over_next) begin
                     r_state <= S_OVER;
                     r_back1 <= BK_NONE;
                     r_back2 <= BK_NONE;
                     r_tmr1  <= 4'd0;
                     r_tmr2  <= 4'd0;
                     r_p1win <= (w_hp2_next == 7'd0) && (w_hp1_next != 7'd0);
                     r_p2win <= (w_hp1_next == 7'd0) && (w_hp2_next != 7'd0);
                     if ((w_hp1_next == 7'd0) && (w_hp2_next == 7'd0)) begin
                        r_p1win <= 1'b1;
                        r_p2win <= 1'b1;
                     end
                  end else begin
                     r_back1 <= w_back1_next;
                     r_back2 <= w_back2_next;
                     r_tmr1  <= w_tmr1_next;
                     r_tmr2  <= w_tmr2_next;
                  end
               end
               S_OVER: begin
                  r_back1 <= BK_NONE;
                  r_back2 <= BK_NONE;
                  r_tmr1  <= 4'd0;
                  r_tmr2  <= 4'd0;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign back1 = r_back1;
   assign back2 = r_back2;
   assign hp1   = r_hp1;
   assign hp2   = r_hp2;
   assign p1win = r_p1win;
   assign p2win = r_p2win;

endmodule

// File: tb/tb_hit_judge.sv
// Self-checking bench for hit_judge: directed scenarios plus randomized play
// compared against a tick-level behavioural model of the game rules.
module tb_hit_judge;

`ifdef HIT_COOLDOWN_EN
   localparam bit CD_EN = 1'b1;
`else
   localparam bit CD_EN = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_clk = 1'b0;
   logic       st = 1'b0;
   logic [9:0] BallX1 = 10'd0, BallY1 = 10'd0, BallX2 = 10'd0, BallY2 = 10'd0;
   logic       fight_1 = 1'b0, kick_1 = 1'b0, dodge_1 = 1'b0, jump_1 = 1'b0;
   logic       fight_2 = 1'b0, kick_2 = 1'b0, dodge_2 = 1'b0, jump_2 = 1'b0;
   logic [1:0] back1, back2;
   logic [6:0] hp1, hp2;
   logic       p1win, p2win;
   logic [19:0] act_vec;

   int n_checks = 0;
   int n_errors = 0;

   // model state: 0 idle, 1 fight, 2 over; index 0 = player 1, 1 = player 2
   int m_state;
   int m_hp[2], m_back[2], m_tmr[2], m_cd[2], m_w[2];

   hit_judge dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .st(st),
      .BallX1(BallX1), .BallY1(BallY1), .BallX2(BallX2), .BallY2(BallY2),
      .fight_1(fight_1), .kick_1(kick_1), .dodge_1(dodge_1), .jump_1(jump_1),
      .fight_2(fight_2), .kick_2(kick_2), .dodge_2(dodge_2), .jump_2(jump_2),
      .back1(back1), .back2(back2), .hp1(hp1), .hp2(hp2),
      .p1win(p1win), .p2win(p2win)
   );

   always #5 Clk = ~Clk;

   assign act_vec = {hp1, hp2, back1, back2, p1win, p2win};

   function automatic logic [19:0] exp_vec();
      return {7'(m_hp[0]), 7'(m_hp[1]), 2'(m_back[0]), 2'(m_back[1]), 1'(m_w[0]), 1'(m_w[1])};
   endfunction

   task automatic m_reset();
      m_state = 0;
      for (int i = 0; i < 2; i++) begin
         m_hp[i] = 100; m_back[i] = 0; m_tmr[i] = 0; m_cd[i] = 0; m_w[i] = 0;
      end
   endtask

   task automatic m_step();
      int dx, dy, a, v;
      int nt[2], nb[2], nh[2], ncd[2];
      bit f[2], k[2], d[2], j[2];
      bit kick_ok, punch_ok;
      f = '{fight_1, fight_2}; k = '{kick_1, kick_2};
      d = '{dodge_1, dodge_2}; j = '{jump_1, jump_2};
      dx = (BallX1 > BallX2) ? int'(BallX1) - int'(BallX2) : int'(BallX2) - int'(BallX1);
      dy = (BallY1 > BallY2) ? int'(BallY1) - int'(BallY2) : int'(BallY2) - int'(BallY1);
      if (!st) begin
         m_state = 0;
         for (int i = 0; i < 2; i++) begin
            m_back[i] = 0; m_tmr[i] = 0; m_cd[i] = 0; m_w[i] = 0;
         end
      end else if (m_state == 0) begin
         m_state = 1;
         for (int i = 0; i < 2; i++) begin
            m_hp[i] = 100; m_back[i] = 0; m_tmr[i] = 0; m_cd[i] = 0; m_w[i] = 0;
         end
      end else if (m_state == 1) begin
         for (int i = 0; i < 2; i++) begin
            nt[i]  = (m_tmr[i] > 0) ? m_tmr[i] - 1 : 0;
            nb[i]  = (nt[i] == 0) ? 0 : m_back[i];
            nh[i]  = m_hp[i];
            ncd[i] = (m_cd[i] > 0) ? m_cd[i] - 1 : 0;
         end
         for (a = 0; a < 2; a++) begin
            v = 1 - a;
            kick_ok  = k[a] && (dx <= 70);
            punch_ok = f[a] && (dx <= 60);
            if ((kick_ok || punch_ok) && (dy <= 50) && !(m_back[v] == 2 && nt[v] != 0)
                && (!CD_EN || ncd[a] == 0)) begin
               if (d[v]) begin
                  nb[v] = 1; nt[v] = 4; ncd[a] = 12;
               end else if (!kick_ok && j[v]) begin
                  nb[v] = nb[v];
               end else begin
                  nh[v] = m_hp[v] - (kick_ok ? 8 : 5);
                  if (nh[v] < 0) nh[v] = 0;
                  nb[v] = 2; nt[v] = 8; ncd[a] = 12;
               end
            end
         end
         for (int i = 0; i < 2; i++) begin
            m_hp[i] = nh[i]; m_back[i] = nb[i]; m_tmr[i] = nt[i]; m_cd[i] = ncd[i];
         end
         if (nh[0] == 0 || nh[1] == 0) begin
            m_state = 2;
            for (int i = 0; i < 2; i++) begin
               m_back[i] = 0; m_tmr[i] = 0; m_cd[i] = 0;
            end
            m_w[0] = (nh[1] == 0) ? 1 : 0;
            m_w[1] = (nh[0] == 0) ? 1 : 0;
         end
      end
   endtask

   task automatic clear_actions();
      fight_1 = 1'b0; kick_1 = 1'b0; dodge_1 = 1'b0; jump_1 = 1'b0;
      fight_2 = 1'b0; kick_2 = 1'b0; dodge_2 = 1'b0; jump_2 = 1'b0;
   endtask

   // One frame strobe: model steps, DUT sees a synchronized edge; sample #1 after an edge.
   task automatic advance();
      m_step();
      frame_clk = 1'b1;
      repeat (4) @(posedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      m_reset();
      n_checks++;
      if (act_vec !== {7'd100, 7'd100, 2'd0, 2'd0, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL reset_state: got %h expected %h", act_vec, {7'd100, 7'd100, 6'd0});
      end
      Reset = 1'b0;
      @(posedge Clk);
      #1;
   endtask

   task automatic test_punch();
      BallX1 = 10'd100; BallX2 = 10'd150; BallY1 = 10'd200; BallY2 = 10'd200;
      st = 1'b1;
      advance();
      fight_1 = 1'b1;
      advance();
      fight_1 = 1'b0;
      n_checks++;
      if (hp2 !== 7'd95 || back2 !== 2'd2) begin
         n_errors++;
         $display("FAIL punch_hit: got hp2=%0d back2=%0d expected hp2=95 back2=2", hp2, back2);
      end
      for (int t = 0; t < 8; t++) begin
         advance();
         n_checks++;
         if (back2 !== ((t < 7) ? 2'd2 : 2'd0) || act_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL punch_stun t=%0d: got %h expected %h", t, act_vec, exp_vec());
         end
      end
   endtask

   task automatic test_kick_range();
      logic [6:0] h;
      h = hp2;
      BallX2 = 10'd165; kick_1 = 1'b1;
      advance();
      kick_1 = 1'b0;
      n_checks++;
      if (hp2 !== h - 7'd8) begin
         n_errors++;
         $display("FAIL kick_in_range: got hp2=%0d expected %0d", hp2, h - 7'd8);
      end
      for (int t = 0; t < 8; t++) advance();
      h = hp2;
      BallX2 = 10'd175; kick_1 = 1'b1;
      advance();
      kick_1 = 1'b0;
      n_checks++;
      if (hp2 !== h || back2 !== 2'd0) begin
         n_errors++;
         $display("FAIL kick_out_of_range: got hp2=%0d back2=%0d expected %0d 0", hp2, back2, h);
      end
   endtask

   task automatic test_dodge_jump();
      logic [6:0] h;
      h = hp2;
      BallX2 = 10'd150; kick_1 = 1'b1; dodge_2 = 1'b1;
      advance();
      clear_actions();
      n_checks++;
      if (hp2 !== h || back2 !== 2'd1) begin
         n_errors++;
         $display("FAIL dodge: got hp2=%0d back2=%0d expected %0d 1", hp2, back2, h);
      end
      for (int t = 0; t < 4; t++) begin
         advance();
         n_checks++;
         if (back2 !== ((t < 3) ? 2'd1 : 2'd0) || act_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL dodge_timer t=%0d: got %h expected %h", t, act_vec, exp_vec());
         end
      end
      for (int t = 0; t < 12; t++) advance();
      fight_1 = 1'b1; jump_2 = 1'b1;
      advance();
      clear_actions();
      n_checks++;
      if (hp2 !== h || back2 !== 2'd0) begin
         n_errors++;
         $display("FAIL jump_miss: got hp2=%0d back2=%0d expected %0d 0", hp2, back2, h);
      end
   endtask

   task automatic test_hold();
      logic [31:0] got_mask, want_mask;
      logic [6:0]  prev;
      int n;
      got_mask = 32'd0; want_mask = 32'd0;
      n = CD_EN ? 24 : 25;
      for (int t = 0; t < 13; t++) advance();
      fight_1 = 1'b1;
      for (int t = 0; t < n; t++) begin
         prev = hp2;
         advance();
         if (hp2 < prev) got_mask[t] = 1'b1;
         if ((CD_EN && t % 12 == 0) || (!CD_EN && t % 8 == 0)) want_mask[t] = 1'b1;
         n_checks++;
         if (act_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL hold_tick t=%0d: got %h expected %h", t, act_vec, exp_vec());
         end
      end
      clear_actions();
      n_checks++;
      if (got_mask !== want_mask) begin
         n_errors++;
         $display("FAIL hold_hits: got mask %h expected %h", got_mask, want_mask);
      end
   endtask

   task automatic test_ko();
      st = 1'b0; advance();
      st = 1'b1; advance();
      BallX1 = 10'd100; BallX2 = 10'd150; BallY1 = 10'd200; BallY2 = 10'd200;
      for (int i = 0; i < 19; i++) begin
         fight_2 = 1'b1;
         kick_1  = (i < 9);
         fight_1 = (i >= 9 && i < 13);
         advance();
         clear_actions();
         for (int t = 0; t < 11; t++) advance();
      end
      n_checks++;
      if (hp1 !== 7'd5 || hp2 !== 7'd8) begin
         n_errors++;
         $display("FAIL ko_setup: got hp1=%0d hp2=%0d expected 5 8", hp1, hp2);
      end
      fight_1 = 1'b1; kick_2 = 1'b1;
      advance();
      n_checks++;
      if (act_vec !== {7'd0, 7'd3, 2'd0, 2'd0, 1'b0, 1'b1}) begin
         n_errors++;
         $display("FAIL ko_mutual: got %h expected %h", act_vec, {7'd0, 7'd3, 6'b000001});
      end
      advance();
      clear_actions();
      n_checks++;
      if (act_vec !== {7'd0, 7'd3, 2'd0, 2'd0, 1'b0, 1'b1}) begin
         n_errors++;
         $display("FAIL ko_frozen: got %h expected %h", act_vec, {7'd0, 7'd3, 6'b000001});
      end
      st = 1'b0;
      advance();
      n_checks++;
      if (p1win !== 1'b0 || p2win !== 1'b0) begin
         n_errors++;
         $display("FAIL ko_idle_flags: got p1win=%0d p2win=%0d expected 0 0", p1win, p2win);
      end
      st = 1'b1;
      advance();
      n_checks++;
      if (hp1 !== 7'd100 || hp2 !== 7'd100) begin
         n_errors++;
         $display("FAIL ko_restart: got hp1=%0d hp2=%0d expected 100 100", hp1, hp2);
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 200; t++) begin
         st = ($urandom_range(0, 39) != 0);
         BallX1 = 10'd300; BallY1 = 10'd300;
         BallX2 = $urandom_range(0, 1) ? 10'(300 + $urandom_range(55, 75)) : 10'(300 - $urandom_range(55, 75));
         BallY2 = $urandom_range(0, 1) ? 10'(300 + $urandom_range(45, 55)) : 10'(300 - $urandom_range(45, 55));
         fight_1 = ($urandom_range(0, 2) == 0); kick_1 = ($urandom_range(0, 2) == 0);
         dodge_1 = ($urandom_range(0, 4) == 0); jump_1 = ($urandom_range(0, 3) == 0);
         fight_2 = ($urandom_range(0, 2) == 0); kick_2 = ($urandom_range(0, 2) == 0);
         dodge_2 = ($urandom_range(0, 4) == 0); jump_2 = ($urandom_range(0, 3) == 0);
         advance();
         n_checks++;
         if (act_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL random t=%0d: got %h expected %h", t, act_vec, exp_vec());
         end
      end
      clear_actions();
   endtask

   task automatic test_reset_mid();
      st = 1'b0; advance();
      st = 1'b1; advance();
      BallX1 = 10'd100; BallX2 = 10'd150; BallY1 = 10'd200; BallY2 = 10'd200;
      for (int t = 0; t < 13; t++) advance();
      fight_1 = 1'b1;
      advance();
      n_checks++;
      if (back2 !== 2'd2) begin
         n_errors++;
         $display("FAIL reset_mid_setup: got back2=%0d expected 2", back2);
      end
      #2 Reset = 1'b1;
      #1;
      m_reset();
      n_checks++;
      if (act_vec !== {7'd100, 7'd100, 2'd0, 2'd0, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL reset_async: got %h expected %h", act_vec, {7'd100, 7'd100, 6'd0});
      end
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
      advance();
      n_checks++;
      if (hp2 !== 7'd100 || back2 !== 2'd0 || act_vec !== exp_vec()) begin
         n_errors++;
         $display("FAIL reset_first_tick: got %h expected %h", act_vec, exp_vec());
      end
      clear_actions();
   endtask

   initial begin
      test_reset();
      test_punch();
      test_kick_range();
      test_dodge_jump();
      test_hold();
      test_ko();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
